// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned IMEM_AW_DEF = 6;

  localparam logic [XLEN-1:0] INSTR_NOP   = 32'h0000_0013;
  localparam logic [XLEN-1:0] INSTR_ECALL = 32'h0000_0073;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // IF/ID register payload handed to decode
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } id_pkt_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory port, execute redirect and IF/ID handshake.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_AW = IMEM_AW_DEF
);

  logic [IMEM_AW-1:0] imem_addr;
  logic [XLEN-1:0]    imem_data;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               id_ready;
  logic               id_valid;
  logic [XLEN-1:0]    id_instr;
  logic [XLEN-1:0]    id_pc;
  logic [XLEN-1:0]    id_pc_plus4;
  logic               halted;

  // fetch stage side
  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready,
    output id_valid,
    output id_instr,
    output id_pc,
    output id_pc_plus4,
    output halted
  );

  // memory / execute / decode side
  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    output id_ready,
    input  id_valid,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4,
    input  halted
  );

endinterface

// File: rtl/fetch_pc_gen.sv
// Combinational next-PC selection: redirect beats halt and stall, else sequential pc+4.
module fetch_pc_gen
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  input  logic            halt_i,
  output logic [XLEN-1:0] next_pc_c_o,
  output logic [XLEN-1:0] pc_plus4_c_o,
  output logic            fetch_c_o
);

  // low target bits are dropped; instructions are word aligned
  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc_i[1:0];

  assign pc_plus4_c_o = pc_i + XLEN'(4);

  always_comb begin
    next_pc_c_o = pc_i;
    fetch_c_o   = 1'b0;
    if (redirect_valid_i) begin
      next_pc_c_o = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (!halt_i && !stall_i) begin
      next_pc_c_o = pc_plus4_c_o;
      fetch_c_o   = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem addressing and IF/ID output register.
// Define FETCH_ECALL_HALT_EN to stop fetching after an ECALL is captured.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     IMEM_AW  = IMEM_AW_DEF
)(
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_c;
  id_pkt_t         id_q, id_d;
  logic            stall_c;
  logic            halt_c;
  logic            fetch_c;

  assign halt_c  = (state_q == HALT);
  assign stall_c = id_q.valid && !bus.id_ready;

  fetch_pc_gen u_pc_gen (
    .pc_i             (pc_q),
    .redirect_valid_i (bus.redirect_valid),
    .redirect_pc_i    (bus.redirect_pc),
    .stall_i          (stall_c),
    .halt_i           (halt_c),
    .next_pc_c_o      (pc_d),
    .pc_plus4_c_o     (pc_plus4_c),
    .fetch_c_o        (fetch_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      id_q    <= '{valid: 1'b0, instr: INSTR_NOP, pc: '0, pc_plus4: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      id_q    <= id_d;
    end
  end

  // IF/ID register and state update; redirect squashes, halt only lets decode drain
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    if (bus.redirect_valid) begin
      id_d.valid = 1'b0;
      state_d    = RUN;
    end else if (halt_c) begin
      if (bus.id_ready) begin
        id_d.valid = 1'b0;
      end
    end else if (fetch_c) begin
      id_d.valid    = 1'b1;
      id_d.instr    = bus.imem_data;
      id_d.pc       = pc_q;
      id_d.pc_plus4 = pc_plus4_c;
`ifdef FETCH_ECALL_HALT_EN
      if (bus.imem_data == INSTR_ECALL) begin
        state_d = HALT;
      end
`endif
    end
  end

  assign bus.imem_addr   = pc_q[IMEM_AW+1:2];
  assign bus.id_valid    = id_q.valid;
  assign bus.id_instr    = id_q.instr;
  assign bus.id_pc       = id_q.pc;
  assign bus.id_pc_plus4 = id_q.pc_plus4;
`ifdef FETCH_ECALL_HALT_EN
  assign bus.halted      = halt_c;
`else
  assign bus.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; covers both FETCH_ECALL_HALT_EN builds.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned AW = 6;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] mem [64];

  fetch_if #(.IMEM_AW(AW)) bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_data = mem[bus.imem_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] instr,
                        input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(bus.id_valid), 32'(v));
    chk({tag, ".instr"}, bus.id_instr, instr);
    chk({tag, ".pc"}, bus.id_pc, pc);
    chk({tag, ".pc4"}, bus.id_pc_plus4, pc + 32'd4);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    mem[38] = INSTR_ECALL;

    rst = 1'b1;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    repeat (2) step();

    // reset values
    chk("rst.valid", 32'(bus.id_valid), 32'd0);
    chk("rst.instr", bus.id_instr, 32'h0000_0013);
    chk("rst.pc", bus.id_pc, 32'd0);
    chk("rst.pc4", bus.id_pc_plus4, 32'd0);
    chk("rst.halted", 32'(bus.halted), 32'd0);
    chk("rst.addr", 32'(bus.imem_addr), 32'd0);
    rst = 1'b0;

    // streaming words 0..2
    for (int i = 0; i < 3; i++) begin
      step();
      chk_id("seq", 1'b1, 32'hC0DE_0000 + 32'(i), 32'(4 * i));
    end

    // stall three cycles at id_pc = 8
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_id("stall", 1'b1, 32'hC0DE_0002, 32'd8);
      chk("stall.addr", 32'(bus.imem_addr), 32'd3);
    end
    bus.id_ready = 1'b1;
    step();
    chk_id("unstall", 1'b1, 32'hC0DE_0003, 32'd12);

    // redirect with misaligned target: one bubble then word 20
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0052;
    step();
    chk("redir.valid", 32'(bus.id_valid), 32'd0);
    chk("redir.addr", 32'(bus.imem_addr), 32'd20);
    bus.redirect_valid = 1'b0;
    step();
    chk_id("redir.tgt", 1'b1, 32'hC0DE_0014, 32'h50);

    // redirect while stalled drops the stalled instruction
    bus.id_ready = 1'b0;
    step();
    chk_id("stall2", 1'b1, 32'hC0DE_0014, 32'h50);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0098;
    step();
    chk("sredir.valid", 32'(bus.id_valid), 32'd0);
    bus.redirect_valid = 1'b0;
    step();
    chk_id("ecall", 1'b1, INSTR_ECALL, 32'd152);
    chk("ecall.addr", 32'(bus.imem_addr), 32'd39);

`ifdef FETCH_ECALL_HALT_EN
    chk("ecall.halted", 32'(bus.halted), 32'd1);
    step();
    chk_id("halt.held", 1'b1, INSTR_ECALL, 32'd152);
    bus.id_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("halt.valid", 32'(bus.id_valid), 32'd0);
      chk("halt.halted", 32'(bus.halted), 32'd1);
      chk("halt.addr", 32'(bus.imem_addr), 32'd39);
    end
`else
    chk("ecall.halted", 32'(bus.halted), 32'd0);
    bus.id_ready = 1'b1;
    step();
    chk_id("post.ecall", 1'b1, 32'hC0DE_0027, 32'd156);
    chk("post.halted", 32'(bus.halted), 32'd0);
`endif

    // redirect to 0 resumes from word 0
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    step();
    chk("r0.valid", 32'(bus.id_valid), 32'd0);
    chk("r0.halted", 32'(bus.halted), 32'd0);
    chk("r0.addr", 32'(bus.imem_addr), 32'd0);
    bus.redirect_valid = 1'b0;
    step();
    chk_id("r0.tgt", 1'b1, 32'hC0DE_0000, 32'd0);

    // imem address wraps past 256 bytes while pc keeps counting
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd252;
    step();
    chk("wrap.addr63", 32'(bus.imem_addr), 32'd63);
    bus.redirect_valid = 1'b0;
    step();
    chk_id("wrap.63", 1'b1, 32'hC0DE_003F, 32'd252);
    chk("wrap.addr0", 32'(bus.imem_addr), 32'd0);
    step();
    chk_id("wrap.256", 1'b1, 32'hC0DE_0000, 32'd256);
    chk("wrap.addr1", 32'(bus.imem_addr), 32'd1);

    // pc+4 wraps modulo 2^32
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    step();
    bus.redirect_valid = 1'b0;
    step();
    chk("top.pc", bus.id_pc, 32'hFFFF_FFFC);
    chk("top.pc4", bus.id_pc_plus4, 32'h0000_0000);
    chk("top.instr", bus.id_instr, 32'hC0DE_003F);
    step();
    chk_id("top.wrap", 1'b1, 32'hC0DE_0000, 32'd0);

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("arst.valid", 32'(bus.id_valid), 32'd0);
    chk("arst.instr", bus.id_instr, 32'h0000_0013);
    chk("arst.addr", 32'(bus.imem_addr), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk_id("arst.first", 1'b1, 32'hC0DE_0000, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
